// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_ctrl_pkg
// Description : Shared definitions for the multicycle RV32I control path:
//               opcodes, FSM state encoding, alu_op codes (also consumed by
//               the ALU function decoder) and datapath mux select encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

    // Supported major opcodes (instruction bits [6:0])
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    // Branch funct3 values implemented by this core
    localparam logic [2:0] c_f3_beq = 3'b000;
    localparam logic [2:0] c_f3_bne = 3'b001;

    // Control FSM states
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_LUI      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    // alu_op encodings shared with the ALU function decoder
    localparam logic [1:0] c_alu_add   = 2'b00;
    localparam logic [1:0] c_alu_sub   = 2'b01;
    localparam logic [1:0] c_alu_rtype = 2'b10;
    localparam logic [1:0] c_alu_itype = 2'b11;

    // ALU operand A select
    localparam logic [1:0] c_src_a_pc     = 2'b00;
    localparam logic [1:0] c_src_a_old_pc = 2'b01;
    localparam logic [1:0] c_src_a_rs1    = 2'b10;
    localparam logic [1:0] c_src_a_zero   = 2'b11;

    // ALU operand B select
    localparam logic [1:0] c_src_b_rs2  = 2'b00;
    localparam logic [1:0] c_src_b_imm  = 2'b01;
    localparam logic [1:0] c_src_b_four = 2'b10;

    // Result bus select
    localparam logic [1:0] c_res_aluout = 2'b00;
    localparam logic [1:0] c_res_mem    = 2'b01;
    localparam logic [1:0] c_res_alu    = 2'b10;

    // Only beq and bne are implemented; other branch flavours trap as illegal.
    function automatic logic is_supported_branch(input logic [2:0] funct3);
        return (funct3 == c_f3_beq) || (funct3 == c_f3_bne);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Main control FSM of the multicycle RV32I core. Sequences each
//               instruction through fetch/decode/execute/memory/writeback,
//               drives datapath selects and enables, stalls on mem_ready and
//               traps unsupported opcodes into an absorbing ILLEGAL state.
// Ports       : clk, rst_n (async, active-low)
//               opcode[6:0], funct3[2:0]  - instruction register fields
//               zero                      - ALU zero flag (combinational)
//               mem_ready                 - memory access completes this cycle
//               alu_op, alu_src_a, alu_src_b, result_src, adr_src
//                                         - datapath selects
//               mem_read, mem_write       - memory strobes
//               ir_write, pc_write, reg_write - register enables
//               retire                    - final cycle of each instruction
//               illegal                   - sticky trap flag
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       retire,
    output logic       illegal
);

    state_t r_state;
    state_t w_next_state;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    c_op_load,
                    c_op_store:  w_next_state = S_MEMADR;
                    c_op_rtype:  w_next_state = S_EXECR;
                    c_op_itype:  w_next_state = S_EXECI;
                    c_op_lui:    w_next_state = S_LUI;
                    c_op_branch: w_next_state = is_supported_branch(funct3) ? S_BRANCH : S_ILLEGAL;
                    c_op_jal:    w_next_state = S_JAL;
                    default:     w_next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   w_next_state = (opcode == c_op_load) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (mem_ready) begin
                    w_next_state = S_MEMWB;
                end
            end
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) begin
                    w_next_state = S_FETCH;
                end
            end
            S_EXECR,
            S_EXECI,
            S_LUI:      w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BRANCH:   w_next_state = S_FETCH;
            // JAL loads the target into PC here; ALUWB then writes old PC + 4.
            S_JAL:      w_next_state = S_ALUWB;
            S_ILLEGAL:  w_next_state = S_ILLEGAL;
            // Unused encodings can only be reached by a corrupted state
            // register; trap rather than silently resume.
            default:    w_next_state = S_ILLEGAL;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: Moore on state, except FETCH ir/pc write, MEMWRITE retire
    // (both gated by mem_ready) and BRANCH pc_write (gated by zero).
    // ------------------------------------------------------------------------
    always_comb begin
        alu_op     = c_alu_add;
        alu_src_a  = c_src_a_pc;
        alu_src_b  = c_src_b_rs2;
        result_src = c_res_aluout;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_a  = c_src_a_pc;
                alu_src_b  = c_src_b_four;
                result_src = c_res_alu;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                // Precompute branch/jump target into ALUOut
                alu_src_a = c_src_a_old_pc;
                alu_src_b = c_src_b_imm;
            end
            S_MEMADR: begin
                alu_src_a = c_src_a_rs1;
                alu_src_b = c_src_b_imm;
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                result_src = c_res_mem;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
            end
            S_EXECR: begin
                alu_src_a = c_src_a_rs1;
                alu_src_b = c_src_b_rs2;
                alu_op    = c_alu_rtype;
            end
            S_EXECI: begin
                alu_src_a = c_src_a_rs1;
                alu_src_b = c_src_b_imm;
                alu_op    = c_alu_itype;
            end
            S_LUI: begin
                alu_src_a = c_src_a_zero;
                alu_src_b = c_src_b_imm;
            end
            S_ALUWB: begin
                result_src = c_res_aluout;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = c_src_a_rs1;
                alu_src_b  = c_src_b_rs2;
                alu_op     = c_alu_sub;
                result_src = c_res_aluout;
                retire     = 1'b1;
                // beq takes on zero, bne on non-zero: funct3[0] inverts
                pc_write   = zero ^ funct3[0];
            end
            S_JAL: begin
                alu_src_a  = c_src_a_old_pc;
                alu_src_b  = c_src_b_four;
                result_src = c_res_aluout;
                pc_write   = 1'b1;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. Each instruction is
//               expanded into its list of phases from the instruction class;
//               every cycle the full output vector is compared against the
//               expected vector for that phase and the current inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    typedef enum int {
        PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMREAD, PH_MEMWB, PH_MEMWRITE,
        PH_EXECR, PH_EXECI, PH_LUI, PH_ALUWB, PH_BRANCH, PH_JAL, PH_ILLEGAL
    } ph_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;
    logic       adr_src, mem_read, mem_write, ir_write, pc_write, reg_write;
    logic       retire, illegal;
    logic [15:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_ctrl u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .adr_src    (adr_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .retire     (retire),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign obs = {alu_op, alu_src_a, alu_src_b, result_src, adr_src, mem_read,
                  mem_write, ir_write, pc_write, reg_write, retire, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected output vector for a phase, straight from the per-state table.
    function automatic logic [15:0] expect_out(input ph_t ph, input logic mr,
                                               input logic z, input logic [2:0] f3);
        logic [1:0] aop, a, b, rs;
        logic adr, mrd, mwr, irw, pcw, rw, ret, ill;
        aop = 2'b00; a = 2'b00; b = 2'b00; rs = 2'b00;
        adr = 0; mrd = 0; mwr = 0; irw = 0; pcw = 0; rw = 0; ret = 0; ill = 0;
        case (ph)
            PH_FETCH:    begin mrd = 1; b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            PH_DECODE:   begin a = 2'b01; b = 2'b01; end
            PH_MEMADR:   begin a = 2'b10; b = 2'b01; end
            PH_MEMREAD:  begin adr = 1; mrd = 1; end
            PH_MEMWB:    begin rs = 2'b01; rw = 1; ret = 1; end
            PH_MEMWRITE: begin adr = 1; mwr = 1; ret = mr; end
            PH_EXECR:    begin a = 2'b10; b = 2'b00; aop = 2'b10; end
            PH_EXECI:    begin a = 2'b10; b = 2'b01; aop = 2'b11; end
            PH_LUI:      begin a = 2'b11; b = 2'b01; end
            PH_ALUWB:    begin rw = 1; ret = 1; end
            PH_BRANCH:   begin a = 2'b10; aop = 2'b01; ret = 1; pcw = z ^ f3[0]; end
            PH_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
            PH_ILLEGAL:  begin ill = 1; end
            default:     begin ill = 1; end
        endcase
        return {aop, a, b, rs, adr, mrd, mwr, irw, pcw, rw, ret, ill};
    endfunction

    // One clock cycle: drive inputs after the falling edge, sample, compare.
    task automatic step(input ph_t ph, input logic mr, input logic z, output logic ret);
        @(negedge clk);
        mem_ready = mr;
        zero      = z;
        #1;
        check($sformatf("out_%s", ph.name()), {16'h0, obs}, {16'h0, expect_out(ph, mr, z, funct3)});
        ret = retire;
    endtask

    function automatic int rand_stall();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    // Run one legal instruction. Stall counts < 0 mean randomised.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input int fetch_stall, input int mem_stall, input int exp_cycles);
        ph_t  phs[$];
        int   retires;
        int   cycles;
        logic r;
        int   total_stall;
        opcode = op;
        funct3 = f3;
        retires = 0;
        cycles = 0;
        total_stall = 0;
        phs.push_back(PH_FETCH);
        phs.push_back(PH_DECODE);
        case (op)
            OP_LOAD:   begin phs.push_back(PH_MEMADR); phs.push_back(PH_MEMREAD); phs.push_back(PH_MEMWB); end
            OP_STORE:  begin phs.push_back(PH_MEMADR); phs.push_back(PH_MEMWRITE); end
            OP_R:      begin phs.push_back(PH_EXECR); phs.push_back(PH_ALUWB); end
            OP_I:      begin phs.push_back(PH_EXECI); phs.push_back(PH_ALUWB); end
            OP_LUI:    begin phs.push_back(PH_LUI); phs.push_back(PH_ALUWB); end
            OP_BRANCH: phs.push_back(PH_BRANCH);
            OP_JAL:    begin phs.push_back(PH_JAL); phs.push_back(PH_ALUWB); end
            default:   phs.push_back(PH_ILLEGAL);
        endcase
        foreach (phs[i]) begin
            int n;
            n = 0;
            if (phs[i] == PH_FETCH)
                n = (fetch_stall >= 0) ? fetch_stall : rand_stall();
            else if (phs[i] == PH_MEMREAD || phs[i] == PH_MEMWRITE)
                n = (mem_stall >= 0) ? mem_stall : rand_stall();
            total_stall += n;
            for (int k = 0; k <= n; k++) begin
                step(phs[i], (k == n), 1'($urandom_range(0, 1)), r);
                if (r) retires++;
                cycles++;
            end
        end
        check($sformatf("retire_count_op%b", op), retires, 1);
        if (exp_cycles > 0)
            check($sformatf("latency_op%b", op), cycles - total_stall, exp_cycles);
    endtask

    // Illegal instruction: absorbing for 20 cycles, then cleared by reset.
    task automatic run_illegal(input logic [6:0] op, input logic [2:0] f3);
        logic r;
        int   retires;
        retires = 0;
        opcode = op;
        funct3 = f3;
        step(PH_FETCH, 1'b1, 1'b0, r);
        step(PH_DECODE, 1'b1, 1'b0, r);
        for (int k = 0; k < 20; k++) begin
            step(PH_ILLEGAL, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
            if (r) retires++;
        end
        check("illegal_no_retire", retires, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("illegal_async_reset", {16'h0, obs}, {16'h0, expect_out(PH_FETCH, 1'b0, zero, f3)});
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic r;
        int   cls;
        // Reset state: FETCH outputs while rst_n is low
        #1;
        check("reset_state", {16'h0, obs}, {16'h0, expect_out(PH_FETCH, 1'b0, 1'b0, 3'b000)});
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed cases with mem_ready high except where a stall is wanted
        run_instr(OP_R,      3'b000, 0, 0, 4);
        run_instr(OP_LOAD,   3'b010, 0, 3, 5);
        run_instr(OP_BRANCH, 3'b000, 0, 0, 3);
        run_instr(OP_BRANCH, 3'b001, 0, 0, 3);
        run_instr(OP_JAL,    3'b000, 0, 0, 4);
        run_instr(OP_STORE,  3'b010, 0, 0, 4);
        run_instr(OP_I,      3'b000, 0, 0, 4);
        run_instr(OP_LUI,    3'b000, 0, 0, 4);
        run_instr(OP_STORE,  3'b010, 2, 2, 4);

        // Randomised instruction stream with random stalls and zero flag
        for (int n = 0; n < 200; n++) begin
            cls = int'($urandom_range(0, 7));
            case (cls)
                0: run_instr(OP_LOAD,   3'($urandom), -1, -1, 5);
                1: run_instr(OP_STORE,  3'($urandom), -1, -1, 4);
                2: run_instr(OP_R,      3'($urandom), -1, -1, 4);
                3: run_instr(OP_I,      3'($urandom), -1, -1, 4);
                4: run_instr(OP_LUI,    3'($urandom), -1, -1, 4);
                5: run_instr(OP_BRANCH, 3'b000,       -1, -1, 3);
                6: run_instr(OP_BRANCH, 3'b001,       -1, -1, 3);
                default: run_instr(OP_JAL, 3'($urandom), -1, -1, 4);
            endcase
        end

        // Unsupported opcodes and branch funct3 values
        run_illegal(OP_SYSTEM, 3'b000);
        run_instr(OP_R, 3'b000, 0, 0, 4);
        run_illegal(7'b1100111, 3'b000);
        run_illegal(OP_BRANCH, 3'(4 + $urandom_range(0, 3)));
        run_illegal(7'b0010111, 3'b000);

        // Reset asserted while a store is stalled in MEMWRITE
        opcode = OP_STORE;
        funct3 = 3'b010;
        step(PH_FETCH, 1'b1, 1'b0, r);
        step(PH_DECODE, 1'b1, 1'b0, r);
        step(PH_MEMADR, 1'b1, 1'b0, r);
        step(PH_MEMWRITE, 1'b0, 1'b0, r);
        #1 rst_n = 1'b0;
        #1;
        check("stall_reset_mem_write", {31'h0, mem_write}, 32'h0);
        check("stall_reset_outputs", {16'h0, obs}, {16'h0, expect_out(PH_FETCH, 1'b0, 1'b0, funct3)});
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_instr(OP_LOAD, 3'b010, 0, 0, 5);
        run_instr(OP_BRANCH, 3'b001, 1, 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the bench always terminates
    initial begin
        #2000000;
        n_errors++;
        $display("FAIL timeout: observed no completion, required finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
